sha256_multiblock_core: RTL

SHA256_MULTIBLOCK_CORE -- requirements
Module: sha256_multiblock_core

---
 rtl/sha256_pkg.sv | 76 +++++++
 rtl/sha256_round.sv | 30 +++
 rtl/sha256_multiblock_core.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg -- shared definitions for the multi-block SHA-256 core.
//   - stateT          : controller states
//   - workT           : the eight working variables a..h
//   - K, IV           : round constants and initial hash value
//   - SECOND_PASS_PAD : padding tail that follows a 256-bit digest in double mode
//   - ch, maj, Sigma0, Sigma1, sigma0, sigma1 : SHA-256 logical functions
package sha256_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ROUND,
      FINAL,
      REPAD,
      OUT
   } stateT;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [31:0] d;
      logic [31:0] e;
      logic [31:0] f;
      logic [31:0] g;
      logic [31:0] h;
   } workT;

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [31:0] IV [0:7] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   // Second-pass message is exactly the 256-bit first digest: append the 1 bit,
   // zero-fill up to the 64-bit length field, and encode a length of 256.
   localparam logic [255:0] SECOND_PASS_PAD = {32'h80000000, 160'h0, 64'd256};

   function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

   function automatic logic [31:0] Sigma0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] Sigma1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] sigma0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sigma1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round -- one combinational SHA-256 compression round.
//   inWork  : working variables a..h before the round
//   w       : message schedule word for this round
//   k       : round constant for this round
//   outWork : working variables a..h after the round
module sha256_round
   import sha256_pkg::*;
(
   input  workT        inWork,
   input  logic [31:0] w,
   input  logic [31:0] k,
   output workT        outWork
);

   logic [31:0] t1;
   logic [31:0] t2;

   assign t1 = inWork.h + Sigma1(inWork.e) + ch(inWork.e, inWork.f, inWork.g) + k + w;
   assign t2 = Sigma0(inWork.a) + maj(inWork.a, inWork.b, inWork.c);

   assign outWork.a = t1 + t2;
   assign outWork.b = inWork.a;
   assign outWork.c = inWork.b;
   assign outWork.d = inWork.c;
   assign outWork.e = inWork.d + t1;
   assign outWork.f = inWork.e;
   assign outWork.g = inWork.f;
   assign outWork.h = inWork.g;

endmodule

// File: rtl/sha256_multiblock_core.sv
// sha256_multiblock_core -- SHA-256 over pre-padded 512-bit blocks, with an
// optional second pass that hashes the first digest (double SHA-256).
//   clk, n_rst        : clock, asynchronous active-low reset
//   blk_valid/ready   : block handshake; ready only while idle
//   blk_data          : 512-bit block, word 0 in [511:480]
//   blk_first/last    : block starts / ends a message
//   double_mode       : taken with the last block; hash the digest again
//   digest_valid/ready: digest handshake
//   digest            : H0..H7, H0 in [255:224]; always shows the stored H
//   busy              : core is not idle
module sha256_multiblock_core
   import sha256_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1,
   parameter bit DOUBLE_EN        = 1'b1
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         blk_valid,
   output logic         blk_ready,
   input  logic [511:0] blk_data,
   input  logic         blk_first,
   input  logic         blk_last,
   input  logic         double_mode,
   output logic         digest_valid,
   input  logic         digest_ready,
   output logic [255:0] digest,
   output logic         busy
);

   if ((ROUNDS_PER_CYCLE < 1) || (ROUNDS_PER_CYCLE > 8) || ((64 % ROUNDS_PER_CYCLE) != 0)) begin : gBadRoundsPerCycle
      $error("sha256_multiblock_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
   end

   // Counter value at the start of the final ROUND cycle of a block.
   localparam logic [5:0] LAST_CNT = 6'(64 - ROUNDS_PER_CYCLE);

   stateT        state;
   stateT        nextState;
   logic [5:0]   roundCnt;
   workT         work;
   workT         roundOut;
   logic [31:0]  win [16];
   logic [31:0]  winNext [16];
   logic [31:0]  winLoad [16];
   logic [31:0]  ext [16 + ROUNDS_PER_CYCLE];
   logic [31:0]  hReg [0:7];
   logic [31:0]  hSum [0:7];
   logic [31:0]  workWords [0:7];
   logic [255:0] hCat;
   logic [255:0] ivCat;
   logic [511:0] srcBlock;
   logic         lastFlag;
   logic         dblFlag;
   logic         useIv;

   assign hCat  = {hReg[0], hReg[1], hReg[2], hReg[3], hReg[4], hReg[5], hReg[6], hReg[7]};
   assign ivCat = {IV[0], IV[1], IV[2], IV[3], IV[4], IV[5], IV[6], IV[7]};

   assign blk_ready    = (state == IDLE);
   assign busy         = (state != IDLE);
   assign digest_valid = (state == OUT);
   assign digest       = hCat;

   // Round chain: stage i consumes window word i, so one cycle covers rounds
   // roundCnt .. roundCnt+ROUNDS_PER_CYCLE-1.
   for (genvar i = 0; i < ROUNDS_PER_CYCLE; i++) begin : gRound
      workT stageIn;
      workT stageOut;
      if (i == 0) begin : gHead
         assign stageIn = work;
      end else begin : gLink
         assign stageIn = gRound[i-1].stageOut;
      end
      sha256_round uRound (
         .inWork  (stageIn),
         .w       (win[i]),
         .k       (K[roundCnt + 6'(i)]),
         .outWork (stageOut)
      );
   end
   assign roundOut = gRound[ROUNDS_PER_CYCLE-1].stageOut;

   // Schedule window: extend by ROUNDS_PER_CYCLE words, then drop the oldest
   // ROUNDS_PER_CYCLE. Words computed past t=63 are never consumed.
   always_comb begin
      for (int j = 0; j < 16; j++) ext[j] = win[j];
      for (int m = 0; m < ROUNDS_PER_CYCLE; m++) begin
         ext[16 + m] = sigma1(ext[14 + m]) + ext[9 + m] + sigma0(ext[1 + m]) + ext[m];
      end
      for (int j = 0; j < 16; j++) winNext[j] = ext[j + ROUNDS_PER_CYCLE];
   end

   // The second pass reuses the block loader with the digest plus fixed padding.
   assign srcBlock = (state == REPAD) ? {hCat, SECOND_PASS_PAD} : blk_data;

   always_comb begin
      for (int j = 0; j < 16; j++) winLoad[j] = srcBlock[511 - 32*j -: 32];
   end

   always_comb begin
      workWords = '{work.a, work.b, work.c, work.d, work.e, work.f, work.g, work.h};
      for (int i = 0; i < 8; i++) hSum[i] = (useIv ? IV[i] : hReg[i]) + workWords[i];
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= IDLE;
      else        state <= nextState;
   end

   // NOTE: nextState is defaulted before the case so no path leaves it
   // unassigned, which would infer a latch.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (blk_valid) nextState = ROUND;
         ROUND:   if (roundCnt == LAST_CNT) nextState = FINAL;
         FINAL: begin
            if (!lastFlag)    nextState = IDLE;
            else if (dblFlag) nextState = REPAD;
            else              nextState = OUT;
         end
         REPAD:   nextState = ROUND;
         OUT:     if (digest_ready) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // NOTE: the schedule window and working registers are reset explicitly so
   // an aborted operation leaves no stale message data behind; H returns to the
   // IV so a headless continuation block chains from a clean state.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         roundCnt <= '0;
         work     <= '0;
         win      <= '{default: '0};
         hReg     <= IV;
         lastFlag <= 1'b0;
         dblFlag  <= 1'b0;
         useIv    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (blk_valid) begin
                  lastFlag <= blk_last;
                  dblFlag  <= double_mode & DOUBLE_EN;
                  useIv    <= blk_first;
                  win      <= winLoad;
                  work     <= blk_first ? workT'(ivCat) : workT'(hCat);
                  roundCnt <= '0;
               end
            end
            ROUND: begin
               work     <= roundOut;
               win      <= winNext;
               roundCnt <= roundCnt + 6'(ROUNDS_PER_CYCLE);
            end
            FINAL: begin
               hReg <= hSum;
            end
            REPAD: begin
               win      <= winLoad;
               work     <= workT'(ivCat);
               useIv    <= 1'b1;
               dblFlag  <= 1'b0;
               lastFlag <= 1'b1;
               roundCnt <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule
